// File: rtl/eth_cmd_pkg.sv
// Shared types and constants for the Ethernet command decoder: FSM states,
// register map addresses, frame geometry and register reset values.
package eth_cmd_pkg;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_e;

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_CNT_TH  = 8'h01;
  localparam logic [7:0] ADDR_IDLE_TH = 8'h02;
  localparam logic [7:0] ADDR_TRIG_W  = 8'h03;
  localparam logic [7:0] ADDR_DMAC_HI = 8'h04;
  localparam logic [7:0] ADDR_DMAC_LO = 8'h05;
  localparam logic [7:0] ADDR_SMAC_HI = 8'h06;
  localparam logic [7:0] ADDR_SMAC_LO = 8'h07;

  localparam int HDR_LEN = 14;
  localparam int REC_LEN = 5;
  localparam logic [3:0] HDR_LAST = 4'(HDR_LEN - 1);
  localparam logic [2:0] REC_LAST = 3'(REC_LEN - 1);

  localparam logic [9:0]  RST_TRIGGER_WIDTH = 10'd4;
  localparam logic [11:0] RST_COUNTER_TH    = 12'd64;
  localparam logic [15:0] RST_IDLE_TH       = 16'd1000;

  // Byte idx of a MAC address as it appears on the wire (idx 0 = first byte).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      3'd5:    b = mac[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/eth_cmd_regfile.sv
// Run-control register map written by decoded command records; also counts
// records that target an unmapped address.
module eth_cmd_regfile #(
  parameter logic [47:0] DEF_D_MAC = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] DEF_S_MAC = 48'h0200_0000_0001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        commit,
  input  logic [7:0]  addr,
  input  logic [31:0] data,
  output logic        soft_reset,
  output logic        tds_mode,
  output logic [3:0]  enable,
  output logic        debug_enable,
  output logic        enable_trigger,
  output logic [9:0]  trigger_width,
  output logic [11:0] counter_th,
  output logic [15:0] idle_counter_number_th,
  output logic [47:0] D_MAC_add,
  output logic [47:0] S_MAC_add,
  output logic [15:0] bad_addr_cnt
);
  import eth_cmd_pkg::*;

  logic        soft_reset_q, soft_reset_d;
  logic        tds_mode_q, tds_mode_d;
  logic [3:0]  enable_q, enable_d;
  logic        debug_enable_q, debug_enable_d;
  logic        enable_trigger_q, enable_trigger_d;
  logic [9:0]  trigger_width_q, trigger_width_d;
  logic [11:0] counter_th_q, counter_th_d;
  logic [15:0] idle_th_q, idle_th_d;
  logic [47:0] d_mac_q, d_mac_d;
  logic [47:0] s_mac_q, s_mac_d;
  logic [15:0] bad_addr_cnt_q, bad_addr_cnt_d;

  always_comb begin
    soft_reset_d     = soft_reset_q;
    tds_mode_d       = tds_mode_q;
    enable_d         = enable_q;
    debug_enable_d   = debug_enable_q;
    enable_trigger_d = enable_trigger_q;
    trigger_width_d  = trigger_width_q;
    counter_th_d     = counter_th_q;
    idle_th_d        = idle_th_q;
    d_mac_d          = d_mac_q;
    s_mac_d          = s_mac_q;
    bad_addr_cnt_d   = bad_addr_cnt_q;
    if (commit) begin
      case (addr)
        ADDR_CTRL: begin
          soft_reset_d     = data[0];
          tds_mode_d       = data[1];
          enable_d         = data[7:4];
          debug_enable_d   = data[8];
          enable_trigger_d = data[9];
        end
        ADDR_CNT_TH:  counter_th_d    = data[11:0];
        ADDR_IDLE_TH: idle_th_d       = data[15:0];
        ADDR_TRIG_W:  trigger_width_d = data[9:0];
        ADDR_DMAC_HI: d_mac_d         = {data[15:0], d_mac_q[31:0]};
        ADDR_DMAC_LO: d_mac_d         = {d_mac_q[47:32], data};
        ADDR_SMAC_HI: s_mac_d         = {data[15:0], s_mac_q[31:0]};
        ADDR_SMAC_LO: s_mac_d         = {s_mac_q[47:32], data};
        default:      bad_addr_cnt_d  = bad_addr_cnt_q + 16'd1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      soft_reset_q     <= 1'b0;
      tds_mode_q       <= 1'b0;
      enable_q         <= 4'h0;
      debug_enable_q   <= 1'b0;
      enable_trigger_q <= 1'b0;
      trigger_width_q  <= RST_TRIGGER_WIDTH;
      counter_th_q     <= RST_COUNTER_TH;
      idle_th_q        <= RST_IDLE_TH;
      d_mac_q          <= DEF_D_MAC;
      s_mac_q          <= DEF_S_MAC;
      bad_addr_cnt_q   <= 16'd0;
    end else begin
      soft_reset_q     <= soft_reset_d;
      tds_mode_q       <= tds_mode_d;
      enable_q         <= enable_d;
      debug_enable_q   <= debug_enable_d;
      enable_trigger_q <= enable_trigger_d;
      trigger_width_q  <= trigger_width_d;
      counter_th_q     <= counter_th_d;
      idle_th_q        <= idle_th_d;
      d_mac_q          <= d_mac_d;
      s_mac_q          <= s_mac_d;
      bad_addr_cnt_q   <= bad_addr_cnt_d;
    end
  end

  assign soft_reset             = soft_reset_q;
  assign tds_mode               = tds_mode_q;
  assign enable                 = enable_q;
  assign debug_enable           = debug_enable_q;
  assign enable_trigger         = enable_trigger_q;
  assign trigger_width          = trigger_width_q;
  assign counter_th             = counter_th_q;
  assign idle_counter_number_th = idle_th_q;
  assign D_MAC_add              = d_mac_q;
  assign S_MAC_add              = s_mac_q;
  assign bad_addr_cnt           = bad_addr_cnt_q;

endmodule

// File: rtl/eth_cmd_decoder.sv
// Receive-side command frame parser: validates the Ethernet header, splits the
// payload into 5-byte register-write records and counts good/dropped frames.
module eth_cmd_decoder #(
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter logic [47:0] DEF_D_MAC = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] DEF_S_MAC = 48'h0200_0000_0001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_axis_fifo_tdata,
  input  logic        rx_axis_fifo_tvalid,
  input  logic        rx_axis_fifo_tlast,
  output logic        rx_axis_fifo_tready,
  output logic        soft_reset,
  output logic        tds_mode,
  output logic [3:0]  enable,
  output logic        debug_enable,
  output logic        enable_trigger,
  output logic [9:0]  trigger_width,
  output logic [11:0] counter_th,
  output logic [15:0] idle_counter_number_th,
  output logic [47:0] D_MAC_add,
  output logic [47:0] S_MAC_add,
  output logic [15:0] good_frame_cnt,
  output logic [15:0] drop_frame_cnt,
  output logic [15:0] bad_addr_cnt
);
  import eth_cmd_pkg::*;

  state_e      state_q, state_d;
  logic [3:0]  hdr_idx_q, hdr_idx_d;
  logic [2:0]  rec_idx_q, rec_idx_d;
  logic [31:0] rec_q, rec_d;
  logic        own_q, own_d;
  logic        bcast_q, bcast_d;
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        tready_q, tready_d;

  logic        xfer;
  logic        own_m, bc_m, hdr_ok;
  logic        commit;
  logic [7:0]  commit_addr;
  logic [31:0] commit_data;

  assign xfer = rx_axis_fifo_tvalid && tready_q;

  // Header byte check. S_MAC_add can only change during a payload, so the
  // live value here is the one held at frame start.
  always_comb begin
    own_m  = 1'b0;
    bc_m   = 1'b0;
    hdr_ok = 1'b1;
    if (hdr_idx_q < 4'd6) begin
      own_m  = ((hdr_idx_q == 4'd0) || own_q) &&
               (rx_axis_fifo_tdata == mac_byte(S_MAC_add, hdr_idx_q[2:0]));
      bc_m   = ((hdr_idx_q == 4'd0) || bcast_q) && (rx_axis_fifo_tdata == 8'hFF);
      hdr_ok = own_m || bc_m;
    end else if (hdr_idx_q == 4'd12) begin
      hdr_ok = (rx_axis_fifo_tdata == ETHERTYPE[15:8]);
    end else if (hdr_idx_q == HDR_LAST) begin
      hdr_ok = (rx_axis_fifo_tdata == ETHERTYPE[7:0]);
    end
  end

  always_comb begin
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    rec_idx_d   = rec_idx_q;
    rec_d       = rec_q;
    own_d       = own_q;
    bcast_d     = bcast_q;
    good_cnt_d  = good_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    tready_d    = 1'b1;
    commit      = 1'b0;
    commit_addr = rec_q[31:24];
    commit_data = {rec_q[23:0], rx_axis_fifo_tdata};
    case (state_q)
      ST_HDR: begin
        if (xfer) begin
          if (hdr_idx_q < 4'd6) begin
            own_d   = own_m;
            bcast_d = bc_m;
          end
          if (!hdr_ok) begin
            hdr_idx_d = 4'd0;
            if (rx_axis_fifo_tlast) drop_cnt_d = drop_cnt_q + 16'd1;
            else                    state_d    = ST_DROP;
          end else if (rx_axis_fifo_tlast) begin
            hdr_idx_d  = 4'd0;
            drop_cnt_d = drop_cnt_q + 16'd1;
          end else if (hdr_idx_q == HDR_LAST) begin
            hdr_idx_d = 4'd0;
            rec_idx_d = 3'd0;
            state_d   = ST_PAYLOAD;
          end else begin
            hdr_idx_d = hdr_idx_q + 4'd1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (xfer) begin
          rec_d = {rec_q[23:0], rx_axis_fifo_tdata};
          if (rec_idx_q == REC_LAST) begin
            commit    = 1'b1;
            rec_idx_d = 3'd0;
            if (rx_axis_fifo_tlast) begin
              good_cnt_d = good_cnt_q + 16'd1;
              state_d    = ST_HDR;
            end
          end else if (rx_axis_fifo_tlast) begin
            // A lone byte after the last full record is an empty tail, not a
            // truncated record.
            if (rec_idx_q == 3'd0) good_cnt_d = good_cnt_q + 16'd1;
            else                   drop_cnt_d = drop_cnt_q + 16'd1;
            rec_idx_d = 3'd0;
            state_d   = ST_HDR;
          end else begin
            rec_idx_d = rec_idx_q + 3'd1;
          end
        end
      end
      ST_DROP: begin
        if (xfer && rx_axis_fifo_tlast) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
          state_d    = ST_HDR;
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_HDR;
      hdr_idx_q  <= 4'd0;
      rec_idx_q  <= 3'd0;
      rec_q      <= 32'd0;
      own_q      <= 1'b0;
      bcast_q    <= 1'b0;
      good_cnt_q <= 16'd0;
      drop_cnt_q <= 16'd0;
      tready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_idx_q  <= hdr_idx_d;
      rec_idx_q  <= rec_idx_d;
      rec_q      <= rec_d;
      own_q      <= own_d;
      bcast_q    <= bcast_d;
      good_cnt_q <= good_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      tready_q   <= tready_d;
    end
  end

  assign rx_axis_fifo_tready = tready_q;
  assign good_frame_cnt      = good_cnt_q;
  assign drop_frame_cnt      = drop_cnt_q;

  eth_cmd_regfile #(
    .DEF_D_MAC (DEF_D_MAC),
    .DEF_S_MAC (DEF_S_MAC)
  ) u_regfile (
    .clk                    (clk),
    .reset_n                (reset_n),
    .commit                 (commit),
    .addr                   (commit_addr),
    .data                   (commit_data),
    .soft_reset             (soft_reset),
    .tds_mode               (tds_mode),
    .enable                 (enable),
    .debug_enable           (debug_enable),
    .enable_trigger         (enable_trigger),
    .trigger_width          (trigger_width),
    .counter_th             (counter_th),
    .idle_counter_number_th (idle_counter_number_th),
    .D_MAC_add              (D_MAC_add),
    .S_MAC_add              (S_MAC_add),
    .bad_addr_cnt           (bad_addr_cnt)
  );

endmodule
